// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue/scoreboard stage.
//   ADDR_W       default register index width
//   NUM_REGS     scoreboard depth (2**ADDR_W)
//   issue_ctrl_s registered payload driven toward the register file and later stages
package issue_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rs0;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rd;
        logic              wen;
    } issue_ctrl_s;

endpackage

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// Pending-write scoreboard: one pending bit per architectural register.
// Optional feature macro: ISSUE_SCOREBOARD_ZERO_REG_EN (register 0 hardwired zero).
// Ports:
//   clk, i_rst                async active-high reset
//   i_set_v / i_set_idx       mark a register pending (issued writer)
//   i_clr_v / i_clr_idx       writeback completion clears a pending bit
//   i_q{0,1,2}_idx            query indices
//   o_q{0,1,2}_eff_c          combinational effective-pending (pending and not cleared this cycle)
//   o_busy                    registered: any pending bit set
//   o_err                     registered sticky: clear of a non-pending register
module reg_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned addr_width_p = ADDR_W
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_set_v,
    input  logic [addr_width_p-1:0] i_set_idx,
    input  logic                    i_clr_v,
    input  logic [addr_width_p-1:0] i_clr_idx,
    input  logic [addr_width_p-1:0] i_q0_idx,
    input  logic [addr_width_p-1:0] i_q1_idx,
    input  logic [addr_width_p-1:0] i_q2_idx,
    output logic                    o_q0_eff_c,
    output logic                    o_q1_eff_c,
    output logic                    o_q2_eff_c,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int unsigned num_regs_lp = 2 ** addr_width_p;

    logic [num_regs_lp-1:0] r_pending;
    logic                   r_busy;
    logic                   r_err;
    logic [num_regs_lp-1:0] w_set;
    logic [num_regs_lp-1:0] w_clr;
    logic [num_regs_lp-1:0] w_eff;
    logic [num_regs_lp-1:0] w_pending_nxt;
    logic                   w_set_en;
    logic                   w_clr_en;

`ifdef ISSUE_SCOREBOARD_ZERO_REG_EN
    // Register 0 is never tracked: its writes and writebacks are ignored.
    assign w_set_en = i_set_v && (i_set_idx != '0);
    assign w_clr_en = i_clr_v && (i_clr_idx != '0);
`else
    assign w_set_en = i_set_v;
    assign w_clr_en = i_clr_v;
`endif

    // Decode set/clear and form effective and next pending vectors; set wins over clear.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_set_en) w_set[i_set_idx] = 1'b1;
        if (w_clr_en) w_clr[i_clr_idx] = 1'b1;
        w_eff         = r_pending & ~w_clr;
        w_pending_nxt = w_eff | w_set;
`ifdef ISSUE_SCOREBOARD_ZERO_REG_EN
        w_eff[0] = 1'b0;
`endif
    end

    assign o_q0_eff_c = w_eff[i_q0_idx];
    assign o_q1_eff_c = w_eff[i_q1_idx];
    assign o_q2_eff_c = w_eff[i_q2_idx];

    // Pending state, busy flag and sticky spurious-writeback error.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_busy    <= |w_pending_nxt;
            if (w_clr_en && !r_pending[i_clr_idx]) r_err <= 1'b1;
        end
    end

    assign o_busy = r_busy;
    assign o_err  = r_err;

endmodule

// File: rtl/issue_scoreboard.sv
// Decode/issue stage: stalls on RAW/WAW hazards against outstanding writes and
// drives registered read addresses toward the register file.
// Optional feature macro: ISSUE_SCOREBOARD_ZERO_REG_EN (register 0 hardwired zero).
// Ports:
//   clk, reset_i                               async active-high reset
//   issue_v_i/rs0/rs1/rd/wen, issue_ready_o    upstream valid/ready (ready is combinational)
//   wb_v_i, wb_rd_i                            writeback completion
//   v_o, yumi_i                                downstream valid / consume
//   read0_o, read1_o, rd_o, wen_o              registered issued fields
//   busy_o, stall_cnt_o, err_o                 status
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned addr_width_p      = ADDR_W,
    parameter int unsigned stall_cnt_width_p = 16
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         issue_v_i,
    input  logic [addr_width_p-1:0]      issue_rs0_i,
    input  logic [addr_width_p-1:0]      issue_rs1_i,
    input  logic [addr_width_p-1:0]      issue_rd_i,
    input  logic                         issue_wen_i,
    output logic                         issue_ready_o,
    input  logic                         wb_v_i,
    input  logic [addr_width_p-1:0]      wb_rd_i,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [addr_width_p-1:0]      read0_o,
    output logic [addr_width_p-1:0]      read1_o,
    output logic [addr_width_p-1:0]      rd_o,
    output logic                         wen_o,
    output logic                         busy_o,
    output logic [stall_cnt_width_p-1:0] stall_cnt_o,
    output logic                         err_o
);

    logic                         r_v;
    issue_ctrl_s                  r_ctrl;
    logic [stall_cnt_width_p-1:0] r_stall_cnt;
    logic                         w_eff_rs0;
    logic                         w_eff_rs1;
    logic                         w_eff_rd;
    logic                         w_hazard;
    logic                         w_ready;
    logic                         w_accept;
    logic                         w_stall;

    reg_scoreboard #(
        .addr_width_p (addr_width_p)
    ) u_sb (
        .clk        (clk),
        .i_rst      (reset_i),
        .i_set_v    (w_accept && issue_wen_i),
        .i_set_idx  (issue_rd_i),
        .i_clr_v    (wb_v_i),
        .i_clr_idx  (wb_rd_i),
        .i_q0_idx   (issue_rs0_i),
        .i_q1_idx   (issue_rs1_i),
        .i_q2_idx   (issue_rd_i),
        .o_q0_eff_c (w_eff_rs0),
        .o_q1_eff_c (w_eff_rs1),
        .o_q2_eff_c (w_eff_rd),
        .o_busy     (busy_o),
        .o_err      (err_o)
    );

    // Same-cycle writeback already masks the effective pending bits, giving zero-bubble wakeup.
    assign w_hazard = w_eff_rs0 || w_eff_rs1 || (issue_wen_i && w_eff_rd);
    assign w_ready  = !w_hazard && (!r_v || yumi_i);
    assign w_accept = issue_v_i && w_ready;
    assign w_stall  = issue_v_i && !w_ready;

    // Output register: load on accept, drop valid when consumed without replacement.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_v    <= 1'b0;
            r_ctrl <= '0;
        end else if (w_accept) begin
            r_v        <= 1'b1;
            r_ctrl.rs0 <= ADDR_W'(issue_rs0_i);
            r_ctrl.rs1 <= ADDR_W'(issue_rs1_i);
            r_ctrl.rd  <= ADDR_W'(issue_rd_i);
            r_ctrl.wen <= issue_wen_i;
        end else if (yumi_i) begin
            r_v <= 1'b0;
        end
    end

    // Saturating count of stalled valid cycles.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + stall_cnt_width_p'(1);
        end
    end

    assign issue_ready_o = w_ready;
    assign v_o           = r_v;
    assign read0_o       = addr_width_p'(r_ctrl.rs0);
    assign read1_o       = addr_width_p'(r_ctrl.rs1);
    assign rd_o          = addr_width_p'(r_ctrl.rd);
    assign wen_o         = r_ctrl.wen;
    assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized and directed stimulus checked against a behavioural scoreboard model.
module tb_issue_scoreboard;

    localparam int AW = 6;
    localparam int SW = 16;
    localparam int NR = 64;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          issue_v_i;
    logic [AW-1:0] issue_rs0_i, issue_rs1_i, issue_rd_i;
    logic          issue_wen_i;
    logic          issue_ready_o;
    logic          wb_v_i;
    logic [AW-1:0] wb_rd_i;
    logic          v_o;
    logic          yumi_i;
    logic [AW-1:0] read0_o, read1_o, rd_o;
    logic          wen_o;
    logic          busy_o;
    logic [SW-1:0] stall_cnt_o;
    logic          err_o;

    always #5 clk = ~clk;

    issue_scoreboard #(.addr_width_p(AW), .stall_cnt_width_p(SW)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .issue_v_i     (issue_v_i),
        .issue_rs0_i   (issue_rs0_i),
        .issue_rs1_i   (issue_rs1_i),
        .issue_rd_i    (issue_rd_i),
        .issue_wen_i   (issue_wen_i),
        .issue_ready_o (issue_ready_o),
        .wb_v_i        (wb_v_i),
        .wb_rd_i       (wb_rd_i),
        .v_o           (v_o),
        .yumi_i        (yumi_i),
        .read0_o       (read0_o),
        .read1_o       (read1_o),
        .rd_o          (rd_o),
        .wen_o         (wen_o),
        .busy_o        (busy_o),
        .stall_cnt_o   (stall_cnt_o),
        .err_o         (err_o)
    );

    // Behavioural model state
    bit            m_pend[NR];
    bit            m_v;
    logic [AW-1:0] m_r0, m_r1, m_rd;
    bit            m_wen;
    int unsigned   m_cnt;
    bit            m_err;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit zero_reg(input logic [AW-1:0] r);
`ifdef ISSUE_SCOREBOARD_ZERO_REG_EN
        return r == '0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_eff(input logic [AW-1:0] r);
        if (zero_reg(r)) return 1'b0;
        return m_pend[r] && !(wb_v_i && wb_rd_i == r);
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = m_eff(issue_rs0_i) || m_eff(issue_rs1_i) || (issue_wen_i && m_eff(issue_rd_i));
        return !hz && (!m_v || yumi_i);
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < NR; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        m_v = 0; m_r0 = '0; m_r1 = '0; m_rd = '0; m_wen = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic idle_inputs();
        issue_v_i = 0; issue_rs0_i = '0; issue_rs1_i = '0; issue_rd_i = '0;
        issue_wen_i = 0; wb_v_i = 0; wb_rd_i = '0; yumi_i = 0;
    endtask

    // Called just after a falling edge; asynchronous reset checked before any clock edge.
    task automatic do_reset();
        reset_i = 1'b1;
        idle_inputs();
        #1;
        check_eq("rst_v", v_o, 0);
        check_eq("rst_read0", read0_o, 0);
        check_eq("rst_read1", read1_o, 0);
        check_eq("rst_rd", rd_o, 0);
        check_eq("rst_wen", wen_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_stall", stall_cnt_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_ready", issue_ready_o, 1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs.
    task automatic cycle(input bit v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [AW-1:0] d, input bit w, input bit wv,
                         input logic [AW-1:0] wr, input bit y);
        bit rdy;
        issue_v_i = v; issue_rs0_i = s0; issue_rs1_i = s1; issue_rd_i = d;
        issue_wen_i = w; wb_v_i = wv; wb_rd_i = wr; yumi_i = y;
        #1;
        rdy = m_ready();
        check_eq("ready", issue_ready_o, rdy);
        @(posedge clk);
        if (v && !rdy && m_cnt != 32'hFFFF) m_cnt++;
        if (wv && !zero_reg(wr)) begin
            if (!m_pend[wr]) m_err = 1'b1;
            m_pend[wr] = 1'b0;
        end
        if (v && rdy) begin
            if (w && !zero_reg(d)) m_pend[d] = 1'b1;
            m_v = 1; m_r0 = s0; m_r1 = s1; m_rd = d; m_wen = w;
        end else if (y) begin
            m_v = 0;
        end
        #1;
        check_eq("v_o", v_o, m_v);
        if (m_v) begin
            check_eq("read0", read0_o, m_r0);
            check_eq("read1", read1_o, m_r1);
            check_eq("rd", rd_o, m_rd);
            check_eq("wen", wen_o, m_wen);
        end
        check_eq("busy", busy_o, m_busy());
        check_eq("stall_cnt", stall_cnt_o, m_cnt);
        check_eq("err", err_o, m_err);
        @(negedge clk);
    endtask

    initial begin
        int q[$];
        logic [AW-1:0] wr;
        bit wv;
        reset_i = 1'b1;
        idle_inputs();
        model_clear();
        @(negedge clk);
        do_reset();

        // First issue
        cycle(1, 1, 2, 3, 1, 0, 0, 0);
        check_eq("first_busy", busy_o, 1);
        check_eq("first_read0", read0_o, 1);

        // RAW on r3: four stall cycles then wakeup on writeback
        cycle(1, 3, 1, 4, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 3, 1, 4, 0, 0, 0, 0);
        check_eq("raw_stall4", stall_cnt_o, 4);
        cycle(1, 3, 1, 4, 0, 1, 3, 0);
        check_eq("raw_issued", v_o, 1);
        check_eq("raw_read0", read0_o, 3);
        check_eq("raw_cleared", busy_o, 0);

        // Set/clear collision on r5
        cycle(1, 1, 2, 5, 1, 0, 0, 1);
        cycle(1, 1, 2, 5, 1, 1, 5, 1);
        check_eq("coll_busy", busy_o, 1);
        check_eq("coll_err", err_o, 0);

        // Backpressure then replacement in the consuming cycle
        for (int i = 0; i < 3; i++) cycle(1, 8, 9, 10, 0, 0, 0, 0);
        check_eq("bp_rd", rd_o, 5);
        cycle(1, 8, 9, 10, 0, 0, 0, 1);
        check_eq("bp_new_read1", read1_o, 9);

        // Spurious writeback, then a stall interrupted by reset
        cycle(0, 0, 0, 0, 0, 1, 7, 0);
        check_eq("spur_err", err_o, 1);
        cycle(1, 1, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0, 0, 0, 0);
        do_reset();

`ifdef ISSUE_SCOREBOARD_ZERO_REG_EN
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 0, 0, 1);
        check_eq("zr_nostall", stall_cnt_o, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 1);
        check_eq("zr_err", err_o, 0);
`endif

        // Randomized phase; writebacks target pending registers only
        for (int n = 0; n < 600; n++) begin
            q.delete();
            for (int i = 0; i < NR; i++) if (m_pend[i]) q.push_back(i);
            wv = 1'b0;
            wr = AW'($urandom_range(0, 7));
            if (q.size() > 0 && ($urandom % 3) == 0) begin
                wv = 1'b1;
                wr = AW'(q[$urandom % q.size()]);
            end
            if (n == 300) do_reset();
            cycle(($urandom % 4) != 0,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), ($urandom % 2) == 1,
                  wv, wr, m_v && (($urandom % 2) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
